// File: rtl/bsignal_capture.sv
// Capture end of a 1-bit sample stream: synchronizes bit_in, samples it at a
// programmable rate, packs samples LSB-first and buffers words in a FWFT FIFO.
module bsignal_capture #(
    parameter int WORD_W     = 16,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [DIV_W-1:0]            div,
    input  logic                        bit_in,
    output logic [WORD_W-1:0]           m_data,
    output logic [$clog2(WORD_W+1)-1:0] m_nbits,
    output logic                        m_last,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic                        overflow,
    output logic                        busy
);
    localparam int NB_W  = $clog2(WORD_W + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [NB_W-1:0] NB_FULL  = NB_W'(WORD_W);
    localparam logic [NB_W-1:0] NB_TOP   = NB_W'(WORD_W - 1);
    localparam logic [PTR_W:0]  CNT_FULL = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;

    typedef struct packed {
        logic              last;
        logic [NB_W-1:0]   nbits;
        logic [WORD_W-1:0] data;
    } entry_t;

    logic              sync1_q, sync2_q;
    state_e            state_q;
    logic [DIV_W-1:0]  div_q, pre_q;
    logic [NB_W-1:0]   bitcnt_q;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic              overflow_q;
    entry_t            mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]    count_q;
    entry_t            push_word, head;
    logic              tick, word_done, push_req, push_ok, pop;

    assign tick      = (state_q == RUN) && (pre_q == div_q);
    assign word_done = tick && (bitcnt_q == NB_TOP);
    assign pop       = m_valid && m_ready;
    assign push_req  = word_done || (state_q == FLUSH);
    // A full FIFO still takes a push when its head leaves in the same cycle.
    assign push_ok   = push_req && ((count_q != CNT_FULL) || pop);

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no latch is inferred.
        shift_d   = shift_q;
        push_word = '{last: 1'b1, nbits: bitcnt_q, data: shift_q};
        if (tick) shift_d = shift_q | (WORD_W'(sync2_q) << bitcnt_q);
        if (state_q == RUN) push_word = '{last: 1'b0, nbits: NB_FULL, data: shift_d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            state_q    <= IDLE;
            div_q      <= '0;
            pre_q      <= '0;
            bitcnt_q   <= '0;
            shift_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            sync1_q <= bit_in;
            sync2_q <= sync1_q;
            case (state_q)
                IDLE: begin
                    if (en) begin
                        state_q    <= RUN;
                        div_q      <= div;
                        pre_q      <= '0;
                        bitcnt_q   <= '0;
                        shift_q    <= '0;
                        overflow_q <= 1'b0;
                    end
                end
                RUN: begin
                    pre_q <= tick ? '0 : pre_q + DIV_W'(1);
                    if (word_done) begin
                        bitcnt_q <= '0;
                        shift_q  <= '0;
                        if (!push_ok) overflow_q <= 1'b1;
                    end else if (tick) begin
                        bitcnt_q <= bitcnt_q + NB_W'(1);
                        shift_q  <= shift_d;
                    end
                    if (!en) state_q <= FLUSH;
                end
                FLUSH: begin
                    if (push_ok) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push_ok && !pop)      count_q <= count_q + (PTR_W+1)'(1);
            else if (!push_ok && pop) count_q <= count_q - (PTR_W+1)'(1);
        end
    end

    // NOTE: FIFO storage has no reset; occupancy lives in the pointers and count.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_word;
    end

    assign m_valid  = (count_q != '0);
    assign head     = m_valid ? mem_q[rd_ptr_q] : '0;
    assign m_data   = head.data;
    assign m_nbits  = head.nbits;
    assign m_last   = head.last;
    assign overflow = overflow_q;
    assign busy     = (state_q != IDLE) || m_valid;
endmodule

// File: tb/tb_bsignal_capture.sv
// Self-checking bench for bsignal_capture: queue-based reference model compared
// every cycle, plus directed captures with hand-computed words and timings.
module tb_bsignal_capture;
    localparam int WORD_W = 16;
    localparam int DIV_W  = 16;
    localparam int DEPTH  = 8;
    localparam int NB_W   = $clog2(WORD_W + 1);

    logic              clk = 1'b0, rst = 1'b0, en = 1'b0, bit_in = 1'b0, m_ready = 1'b0;
    logic [DIV_W-1:0]  div = '0;
    logic [WORD_W-1:0] m_data;
    logic [NB_W-1:0]   m_nbits;
    logic              m_last, m_valid, overflow, busy;

    bsignal_capture #(.WORD_W(WORD_W), .DIV_W(DIV_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .en(en), .div(div), .bit_in(bit_in),
        .m_data(m_data), .m_nbits(m_nbits), .m_last(m_last), .m_valid(m_valid),
        .m_ready(m_ready), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WORD_W-1:0] data;
        int                nbits;
        bit                last;
        int                cyc;
    } word_t;

    int    checks = 0, errors = 0, cyc = 0;
    word_t wlog[$];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum {M_IDLE, M_RUN, M_FLUSH} mphase_e;
    mphase_e ph = M_IDLE;
    word_t   mq[$];
    bit      bits_q[$];
    int      n_run = 0, mdiv = 0;
    bit      ovf = 1'b0, s1 = 1'b0, s2 = 1'b0;

    function automatic word_t pack(input bit b[$], input bit last);
        word_t w;
        w.data = '0;
        foreach (b[k]) w.data[k] = b[k];
        w.nbits = b.size();
        w.last  = last;
        w.cyc   = 0;
        return w;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph = M_IDLE; mq.delete(); bits_q.delete();
            ovf = 1'b0; s1 = 1'b0; s2 = 1'b0; n_run = 0;
        end else begin : model_step
            bit sample, pop, space;
            sample = s2; s2 = s1; s1 = bit_in;
            pop   = (mq.size() != 0) && m_ready;
            space = (mq.size() < DEPTH) || pop;
            if (pop) void'(mq.pop_front());
            case (ph)
                M_IDLE: if (en) begin
                    ph = M_RUN; n_run = 0; mdiv = int'(div); bits_q.delete(); ovf = 1'b0;
                end
                M_RUN: begin
                    if (n_run % (mdiv + 1) == mdiv) begin
                        bits_q.push_back(sample);
                        if (bits_q.size() == WORD_W) begin
                            if (space) mq.push_back(pack(bits_q, 1'b0));
                            else ovf = 1'b1;
                            bits_q.delete();
                        end
                    end
                    n_run++;
                    if (!en) ph = M_FLUSH;
                end
                M_FLUSH: if (space) begin
                    mq.push_back(pack(bits_q, 1'b1));
                    ph = M_IDLE;
                end
                default: ph = M_IDLE;
            endcase
        end
    end

    // Compare process: outputs are stable on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            check("m_valid", m_valid, mq.size() != 0);
            if (mq.size() != 0) begin
                check("m_data", m_data, mq[0].data);
                check("m_nbits", m_nbits, mq[0].nbits);
                check("m_last", m_last, mq[0].last);
            end
            check("overflow", overflow, ovf);
            check("busy", busy, (ph != M_IDLE) || (mq.size() != 0));
            if (m_valid && m_ready) wlog.push_back('{m_data, int'(m_nbits), m_last, cyc});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input bit b, input bit e);
        @(posedge clk);
        #1;
        bit_in = b;
        en     = e;
    endtask

    function automatic bit pat(input int kind, input int i);
        case (kind)
            0:       return (i % 2) == 0;
            1:       return 1'b1;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // Cycle C0 carries the first sample; en is high for n_on cycles, then drops.
    task automatic run_capture(input int dv, input int n_on, input int kind, output int t0);
        div = DIV_W'(dv);
        step(pat(kind, 0), 1'b0);
        t0 = cyc;
        for (int i = 1; i <= n_on; i++) step(pat(kind, i), 1'b1);
        step(pat(kind, n_on + 1), 1'b0);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 3000 && busy; i++) step(1'b0, 1'b0);
        check({name, "_idle"}, busy, 1'b0);
    endtask

    task automatic check_word(input string name, input int idx, input logic [WORD_W-1:0] d,
                              input int nb, input bit l);
        if (idx >= wlog.size()) begin
            checks++;
            errors++;
            $display("FAIL %s: word %0d not popped, only %0d words seen", name, idx, wlog.size());
        end else begin
            check({name, "_data"}, wlog[idx].data, d);
            check({name, "_nbits"}, wlog[idx].nbits, nb);
            check({name, "_last"}, wlog[idx].last, l);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t0;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_data", m_data, 0);
        check("rst_m_nbits", m_nbits, 0);
        check("rst_m_last", m_last, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;

        // Alternating samples, 20 ticks: one full word plus a 4-bit tail.
        m_ready = 1'b1;
        wlog.delete();
        run_capture(0, 20, 0, t0);
        wait_idle("t1");
        check("t1_nwords", wlog.size(), 2);
        check_word("t1_w0", 0, 16'h5555, 16, 1'b0);
        check_word("t1_term", 1, 16'h0005, 4, 1'b1);
        if (wlog.size() > 0) check("t1_latency", wlog[0].cyc - t0, 18);

        // div=3, constant ones: 34 ticks -> two words 64 cycles apart, 2-bit tail.
        wlog.delete();
        run_capture(3, 138, 1, t0);
        wait_idle("t2");
        check("t2_nwords", wlog.size(), 3);
        check_word("t2_w0", 0, 16'hFFFF, 16, 1'b0);
        check_word("t2_w1", 1, 16'hFFFF, 16, 1'b0);
        check_word("t2_term", 2, 16'h0003, 2, 1'b1);
        if (wlog.size() > 1) begin
            check("t2_latency", wlog[0].cyc - t0, 66);
            check("t2_period", wlog[1].cyc - wlog[0].cyc, 64);
        end

        // Stop after five ticks of ones.
        wlog.delete();
        run_capture(0, 5, 1, t0);
        wait_idle("t3");
        check("t3_nwords", wlog.size(), 1);
        check_word("t3_term", 0, 16'h001F, 5, 1'b1);
        check("t3_busy", busy, 1'b0);

        // Stop on the 16th tick: full word, then empty terminating word.
        wlog.delete();
        run_capture(0, 16, 2, t0);
        wait_idle("t4");
        check("t4_nwords", wlog.size(), 2);
        if (wlog.size() > 0) begin
            check("t4_w0_nbits", wlog[0].nbits, 16);
            check("t4_w0_last", wlog[0].last, 1'b0);
        end
        check_word("t4_term", 1, 16'h0000, 0, 1'b1);

        // Consumer stalled: ninth word dropped, terminating word waits for space.
        m_ready = 1'b0;
        wlog.delete();
        run_capture(0, 144, 2, t0);
        repeat (4) step(1'b0, 1'b0);
        check("t5_overflow", overflow, 1'b1);
        check("t5_m_valid", m_valid, 1'b1);
        check("t5_busy", busy, 1'b1);
        m_ready = 1'b1;
        wait_idle("t5");
        check("t5_nwords", wlog.size(), 9);
        check_word("t5_term", 8, 16'h0000, 0, 1'b1);
        wlog.delete();
        run_capture(0, 3, 1, t0);
        wait_idle("t5r");
        check("t5_restart_ovf", overflow, 1'b0);
        check_word("t5r_term", 0, 16'h0007, 3, 1'b1);

        // Reset mid-capture with three words buffered.
        m_ready = 1'b0;
        div = '0;
        step(1'b0, 1'b0);
        repeat (52) step(1'($urandom_range(0, 1)), 1'b1);
        check("t6_pre_valid", m_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_m_valid", m_valid, 1'b0);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_overflow", overflow, 1'b0);
        check("t6_rst_m_data", m_data, 0);
        step(1'b0, 1'b0);
        rst = 1'b0;
        m_ready = 1'b1;
        wlog.delete();
        run_capture(0, 16, 0, t0);
        wait_idle("t6");
        check_word("t6_w0", 0, 16'h5555, 16, 1'b0);
        check_word("t6_term", 1, 16'h0000, 0, 1'b1);
        if (wlog.size() > 0) check("t6_latency", wlog[0].cyc - t0, 18);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
